// File: rtl/mux_pkg.sv
// Shared definitions for the scanning N:1 multiplexer: operating-state enum and width helper.
`default_nettype none

package mux_pkg;

  typedef enum logic [1:0] {
    MAN  = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int cw_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/scan_div.sv
// Scan-step divider: counts 0..DIV-1 and emits a one-cycle tick on the wrap cycle.
`default_nettype none

module scan_div
  import mux_pkg::*;
#(
  parameter int DIV = 25_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic frz_i,
  output logic tick_o
);

  localparam int CNTW = cw_of(DIV);
  localparam logic [CNTW-1:0] LAST = CNTW'(DIV - 1);

  logic [CNTW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (!frz_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/b_mux_n_1_scan.sv
// N:1 registered multiplexer with manual select, timed auto-scan and hold.
// Optional MUX_SKIP_EN adds en_mask so the scan skips disabled channels.
`default_nettype none

module b_mux_n_1_scan
  import mux_pkg::*;
#(
  parameter int W   = 2,
  parameter int N   = 4,
  parameter int DIV = 25_000_000,
  localparam int CW = cw_of(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] d,
  input  logic [CW-1:0]  sel,
  input  logic           mode,
  input  logic           hold,
`ifdef MUX_SKIP_EN
  input  logic [N-1:0]   en_mask,
`endif
  output logic [W-1:0]   y,
  output logic [CW-1:0]  ch,
  output logic           chg
);

  logic [N-1:0] en;
`ifdef MUX_SKIP_EN
  assign en = en_mask;
`else
  assign en = '1;
`endif

  // The operating state has no memory of its own: it is re-decoded from hold/mode every cycle.
  state_e st;
  always_comb begin
    st = MAN;
    if (hold)      st = HOLD;
    else if (mode) st = SCAN;
  end

  logic tick;
  scan_div #(.DIV(DIV)) u_div (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (st == MAN),
    .frz_i  (st == HOLD),
    .tick_o (tick)
  );

  logic [CW-1:0] ch_q, ch_d, nxt, sel_clamped;
  logic [W-1:0]  y_q, y_d, y_mux;
  logic          chg_q, chg_d;

  // Next enabled channel in ascending circular order; stays put if none is enabled.
  always_comb begin
    logic found;
    int   idx;
    nxt   = ch_q;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(ch_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && en[idx]) begin
        nxt   = CW'(idx);
        found = 1'b1;
      end
    end
  end

  assign sel_clamped = (int'(sel) >= N) ? CW'(N - 1) : sel;
  assign y_mux       = en[ch_q] ? d[int'(ch_q)*W +: W] : '0;

  always_comb begin
    ch_d = ch_q;
    y_d  = y_q;
    unique case (st)
      MAN: begin
        ch_d = sel_clamped;
        y_d  = y_mux;
      end
      SCAN: begin
        if (tick) ch_d = nxt;
        y_d = y_mux;
      end
      default: ;
    endcase
    chg_d = (ch_d != ch_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q  <= '0;
      y_q   <= '0;
      chg_q <= 1'b0;
    end else begin
      ch_q  <= ch_d;
      y_q   <= y_d;
      chg_q <= chg_d;
    end
  end

  assign y   = y_q;
  assign ch  = ch_q;
  assign chg = chg_q;

endmodule

`default_nettype wire

// File: doc/b_mux_n_1_scan.md
B_MUX_N_1_SCAN -- requirements
Module: b_mux_n_1_scan

Interface
REQ-001 SHALL have parameter W, default 2, meaning data width per channel (>=1).
REQ-002 SHALL have parameter N, default 4, meaning channel count (>=1); CW = max(1, clog2(N)).
REQ-003 SHALL have parameter DIV, default 25_000_000, meaning clock cycles per scan step (>=1).
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port d  input  N*W  packed channels; channel k = d[k*W +: W].
REQ-007 SHALL have port sel  input  CW  manual channel select.
REQ-008 SHALL have port mode  input  1  0 = manual, 1 = auto-scan.
REQ-009 SHALL have port hold  input  1  freezes all state while 1.
REQ-010 SHALL have port y  output  W  registered selected data.
REQ-011 SHALL have port ch  output  CW  current channel index.
REQ-012 SHALL have port chg  output  1  one-cycle pulse when ch changes value.

Function
REQ-013 SHALL implement FSM states MAN, SCAN, HOLD; hold=1 -> HOLD (dominant), else mode=1 -> SCAN, else MAN; state is evaluated every cycle.
REQ-014 SHALL in MAN load ch <= sel each cycle (1-cycle latency) and keep divider count at 0; sel >= N loads ch <= N-1.
REQ-015 SHALL in SCAN count 0..DIV-1; on the cycle count==DIV-1, count wraps to 0 and ch <= (ch+1) mod N.
REQ-016 SHALL with DIV=1 advance ch every SCAN cycle.
REQ-017 SHALL update y every non-HOLD cycle to d[ch*W +: W] using the ch value held before the edge (y lags a ch change by one cycle).
REQ-018 SHALL in HOLD freeze ch, count and y; leaving HOLD resumes the count from its frozen value.
REQ-019 SHALL on MAN->SCAN start from the current ch with count 0; on SCAN->MAN clear count and take sel on the next edge.
REQ-020 SHALL assert chg for exactly the cycle after the edge where ch took a new value; no pulse if the new value equals the old value.
REQ-021 SHALL with N=1 keep ch=0 permanently and never assert chg.

Reset
REQ-022 SHALL on rst=1, asynchronously and at any time (including mid-count or in HOLD), force ch=0, y=0, chg=0, count=0, state=MAN.
REQ-023 SHALL on the first edge after rst deasserts evaluate state per REQ-013 with no chg pulse from the reset itself.

Configuration
REQ-024 SHALL support macro MUX_SKIP_EN; when defined, add port en_mask  input  N  per-channel enable.
REQ-025 SHALL with MUX_SKIP_EN make SCAN advance to the next enabled channel in ascending circular order, skipping disabled ones within the same step.
REQ-026 SHALL with MUX_SKIP_EN and en_mask all zero hold ch unchanged and force y=0; in MAN, a disabled selected channel yields y=0 while ch=sel.
REQ-027 SHALL without MUX_SKIP_EN omit en_mask and treat all channels as enabled.

Structure
REQ-028 SHALL place the state enum (MAN/SCAN/HOLD) and the CW width function in shared package mux_pkg.
REQ-029 SHALL implement the divider as sub-module scan_div (count, wrap, tick output, clear and freeze inputs).
REQ-030 SHALL keep the design within 120-400 lines of RTL, fully synthesisable, with no latches.

Verification
REQ-031 SHALL cover: W=2,N=4, mode=0, sel=2, d=8'b11_10_01_00 -> ch=2 after 1 edge, y=2'b10 after 2 edges, chg single pulse.
REQ-032 SHALL cover: mode=1, DIV=3, from ch=0 -> ch sequence 0,1,2,3,0 every 3 cycles, chg each step, y follows one cycle later.
REQ-033 SHALL cover: hold=1 mid-count (count=1) for 10 cycles -> ch, y frozen, no chg; after release ch advances 2 cycles later.
REQ-034 SHALL cover: rst pulse asserted mid-scan, between edges -> ch=0,y=0,chg=0 immediately, state=MAN after release.
REQ-035 SHALL cover: MUX_SKIP_EN, en_mask=4'b1010, DIV=1 -> ch sequence 1,3,1,3; en_mask=0 -> ch held, y=0.
